// File: rtl/acid_host.sv
// -----------------------------------------------------------------------------
// acid_host : host end of the cartridge lockout link.
//
// Pulses the cartridge clear, then runs a session of STEPS checked clocks. Each
// RUN clock the cartridge response byte is compared against a bit-exact copy of
// the cartridge's 17-bit LFSR. When unlocking is enabled and the model state is
// matchable, the address driven to the cartridge is the unlock-match address.
//
// Optional feature macro: ACIDH_TRACE_EN (adds PinFSTEP/PinFSIN first-mismatch
// capture outputs).
//
// Ports:
//   PinCLK      in   system clock (state changes on posedge)
//   PinRESETn   in   async active-low reset
//   PinSTART    in   one-clock pulse starting a session (IDLE/DONE only)
//   PinUNLOCK   in   enable match-address injection
//   PinCHAL[8]  in   challenge byte driven when no match is injected
//   PinSIN[8]   in   cartridge response byte
//   PinA[8]     out  address byte to cartridge
//   PinOE       out  active-low cartridge select
//   PinCCLR     out  active-low cartridge clear
//   PinBUSY     out  high in CLEAR and RUN
//   PinDONE     out  session finished
//   PinPASS     out  every response of the session matched
//   PinHITS[8]  out  match-step count, saturating at 255
//   PinFSTEP[8] out  (trace) step index of first mismatch, FF if none
//   PinFSIN[8]  out  (trace) response byte seen at first mismatch
// -----------------------------------------------------------------------------
module acid_host #(
    parameter int STEPS      = 64,
    parameter int CLR_CYCLES = 2
) (
    input  logic       PinCLK,
    input  logic       PinRESETn,
    input  logic       PinSTART,
    input  logic       PinUNLOCK,
    input  logic [7:0] PinCHAL,
    input  logic [7:0] PinSIN,
    output logic [7:0] PinA,
    output logic       PinOE,
    output logic       PinCCLR,
    output logic       PinBUSY,
    output logic       PinDONE,
    output logic       PinPASS,
    output logic [7:0] PinHITS
`ifdef ACIDH_TRACE_EN
    ,
    output logic [7:0] PinFSTEP,
    output logic [7:0] PinFSIN
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int        CW       = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYCLES - 1);
    localparam logic [7:0]    STEP_LAST = 8'(STEPS - 1);

    // Compare value the cartridge matches against for address a.
    function automatic logic [16:0] cmp_f(input logic [7:0] a);
        cmp_f = 17'h13596
              ^ ({17{a[0]}} & 17'h0000C) ^ ({17{a[1]}} & 17'h06000)
              ^ ({17{a[2]}} & 17'h000C0) ^ ({17{a[3]}} & 17'h00030)
              ^ ({17{a[4]}} & 17'h18000) ^ ({17{a[5]}} & 17'h00003)
              ^ ({17{a[6]}} & 17'h00600) ^ ({17{a[7]}} & 17'h01800);
    endfunction

    // State perturbation applied on a match.
    function automatic logic [16:0] x_f(input logic [7:0] a);
        x_f = 17'h0C820
            ^ ({17{a[0]}} & 17'h00004) ^ ({17{a[1]}} & 17'h06000)
            ^ ({17{a[2]}} & 17'h00080) ^ ({17{a[3]}} & 17'h00020)
            ^ ({17{a[4]}} & 17'h08000) ^ ({17{a[7]}} & 17'h00800);
    endfunction

    // Only states whose bit pairs all differ can be hit by some address.
    function automatic logic matchable_f(input logic [16:0] s);
        matchable_f = (s[0]  ^ s[1])  & (s[2]  ^ s[3])  & (s[4]  ^ s[5])
                    & (s[6]  ^ s[7])  & (s[9]  ^ s[10]) & (s[11] ^ s[12])
                    & (s[13] ^ s[14]) & (s[15] ^ s[16]);
    endfunction

    // Address {A7..A0} that makes cmp_f equal the state for a matchable s.
    function automatic logic [7:0] drive_f(input logic [16:0] n, input logic unl,
                                           input logic [7:0] chal);
        if (unl && matchable_f(n))
            drive_f = {n[11], n[9], n[0], n[15], ~n[4], n[6], ~n[13], ~n[2]};
        else
            drive_f = chal;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [16:0]   model_q, model_d;
    logic [7:0]    a_q, a_d;
    logic          oe_q, oe_d, cclr_q, cclr_d, busy_q, busy_d;
    logic          done_q, done_d, pass_q, pass_d;
    logic [7:0]    hits_q, hits_d, step_q, step_d;
    logic [CW-1:0] clr_q, clr_d;

    logic          match, mism, sess_start;
    logic [16:0]   t, e;

    always_comb begin
        match = !oe_q && ((model_q | 17'h00100) == cmp_f(a_q));
        t     = match ? (model_q ^ x_f(a_q)) : model_q;
        e     = {t[0] ^ t[9] ^ t[12] ^ t[16], t[16:1]};
        mism  = (PinSIN != e[7:0]);
        sess_start = ((state_q == S_IDLE) || (state_q == S_DONE)) && PinSTART;
    end

    always_comb begin
        state_d = state_q;
        model_d = model_q;
        a_d     = a_q;
        oe_d    = oe_q;
        cclr_d  = cclr_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        hits_d  = hits_q;
        step_d  = step_q;
        clr_d   = clr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (PinSTART) begin
                    state_d = S_CLEAR;
                    cclr_d  = 1'b0;
                    model_d = 17'h1FFFF;
                    pass_d  = 1'b1;
                    done_d  = 1'b0;
                    hits_d  = 8'h00;
                    busy_d  = 1'b1;
                    step_d  = 8'h00;
                    clr_d   = '0;
                end
            end
            S_CLEAR: begin
                if (clr_q == CLR_LAST) begin
                    cclr_d  = 1'b1;
                    a_d     = drive_f(model_q, PinUNLOCK, PinCHAL);
                    oe_d    = 1'b0;
                    state_d = S_RUN;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            default: begin // S_RUN
                if (mism) pass_d = 1'b0;
                model_d = e;
                if (match && hits_q != 8'hFF) hits_d = hits_q + 8'd1;
                step_d = step_q + 8'd1;
                if (step_q == STEP_LAST) begin
                    a_d     = 8'h00;
                    oe_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    a_d  = drive_f(e, PinUNLOCK, PinCHAL);
                    oe_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge PinCLK or negedge PinRESETn) begin
        if (!PinRESETn) begin
            state_q <= S_IDLE;
            model_q <= 17'h1FFFF;
            a_q     <= 8'h00;
            oe_q    <= 1'b1;
            cclr_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            hits_q  <= 8'h00;
            step_q  <= 8'h00;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            model_q <= model_d;
            a_q     <= a_d;
            oe_q    <= oe_d;
            cclr_q  <= cclr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            hits_q  <= hits_d;
            step_q  <= step_d;
            clr_q   <= clr_d;
        end
    end

    assign PinA    = a_q;
    assign PinOE   = oe_q;
    assign PinCCLR = cclr_q;
    assign PinBUSY = busy_q;
    assign PinDONE = done_q;
    assign PinPASS = pass_q;
    assign PinHITS = hits_q;

`ifdef ACIDH_TRACE_EN
    logic [7:0] fstep_q, fsin_q;

    // pass_q still high means no mismatch yet this session: capture once.
    always_ff @(posedge PinCLK or negedge PinRESETn) begin
        if (!PinRESETn) begin
            fstep_q <= 8'hFF;
            fsin_q  <= 8'h00;
        end else if (sess_start) begin
            fstep_q <= 8'hFF;
            fsin_q  <= 8'h00;
        end else if (state_q == S_RUN && mism && pass_q) begin
            fstep_q <= step_q;
            fsin_q  <= PinSIN;
        end
    end

    assign PinFSTEP = fstep_q;
    assign PinFSIN  = fsin_q;
`endif

endmodule

// File: tb/tb_acid_host.sv
// -----------------------------------------------------------------------------
// Bench for acid_host: a behavioural cartridge lives on the far side of the
// link (steps on negedge, answers on PinSIN) and independently checks the
// addresses the host drives. Sessions come from a fixed table plus random
// sessions; each is checked for clear length, session length, PASS and HITS.
// -----------------------------------------------------------------------------
module tb_acid_host;

    localparam int STEPS = 64;
    localparam int CLR   = 2;

    logic       clk = 1'b0, rstn = 1'b0, start = 1'b0, unlock = 1'b0;
    logic [7:0] chal = 8'h00, sin = 8'h00;
    logic [7:0] PinA, PinHITS;
    logic       PinOE, PinCCLR, PinBUSY, PinDONE, PinPASS;
`ifdef ACIDH_TRACE_EN
    logic [7:0] PinFSTEP, PinFSIN;
`endif

    acid_host #(.STEPS(STEPS), .CLR_CYCLES(CLR)) dut (
        .PinCLK(clk), .PinRESETn(rstn), .PinSTART(start), .PinUNLOCK(unlock),
        .PinCHAL(chal), .PinSIN(sin), .PinA(PinA), .PinOE(PinOE),
        .PinCCLR(PinCCLR), .PinBUSY(PinBUSY), .PinDONE(PinDONE),
        .PinPASS(PinPASS), .PinHITS(PinHITS)
`ifdef ACIDH_TRACE_EN
        , .PinFSTEP(PinFSTEP), .PinFSIN(PinFSIN)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Cartridge reference, written from the published rules as mask tables.
    localparam logic [16:0] CMP_M [8] = '{17'h0000C, 17'h06000, 17'h000C0, 17'h00030,
                                          17'h18000, 17'h00003, 17'h00600, 17'h01800};
    localparam logic [16:0] X_M   [8] = '{17'h00004, 17'h06000, 17'h00080, 17'h00020,
                                          17'h08000, 17'h00000, 17'h00000, 17'h00800};
    localparam int PAIRS [8] = '{0, 2, 4, 6, 9, 11, 13, 15};
    localparam int SRC   [8] = '{2, 13, 6, 4, 15, 0, 9, 11};
    localparam int INV   [8] = '{1, 1, 0, 1, 0, 0, 0, 0};

    function automatic bit tb_match(input logic [16:0] s, input logic [7:0] a);
        logic [16:0] c = 17'h13596;
        for (int i = 0; i < 8; i++) if (a[i]) c ^= CMP_M[i];
        return (s | 17'h00100) == c;
    endfunction

    function automatic logic [16:0] tb_step(input logic [16:0] s, input logic [7:0] a);
        logic [16:0] t = s;
        logic [16:0] x = 17'h0C820;
        logic fb;
        for (int i = 0; i < 8; i++) if (a[i]) x ^= X_M[i];
        if (tb_match(s, a)) t = s ^ x;
        fb = t[0] ^ t[9] ^ t[12] ^ t[16];
        return (t >> 1) | {fb, 16'h0000};
    endfunction

    function automatic bit tb_matchable(input logic [16:0] s);
        for (int i = 0; i < 8; i++) if (s[PAIRS[i]] == s[PAIRS[i]+1]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] tb_inject(input logic [16:0] s);
        logic [7:0] a;
        for (int i = 0; i < 8; i++) a[i] = s[SRC[i]] ^ INV[i][0];
        return a;
    endfunction

    // Cartridge: cleared by PinCCLR, steps on negedge while selected.
    logic [16:0] cstate = 17'h1FFFF;
    int          cstep = 0, chits = 0, err_step = -1;
    logic [7:0]  exp_fsin = 8'h00, ea_n;
    bit          mt_n, inj_n;

    always @(negedge clk) begin
        if (!PinCCLR) begin
            cstate = 17'h1FFFF;
            cstep  = 0;
            chits  = 0;
        end else if (rstn && !PinOE) begin
            inj_n = unlock && tb_matchable(cstate);
            ea_n  = inj_n ? tb_inject(cstate) : chal;
            chk("drive_a", PinA, ea_n);
            mt_n = tb_match(cstate, PinA);
            if (inj_n) chk("inject_matches", mt_n, 1);
            if (mt_n) chits++;
            cstate = tb_step(cstate, PinA);
            sin = cstate[7:0] ^ ((cstep == err_step) ? 8'h01 : 8'h00);
            if (cstep == err_step) exp_fsin = sin;
            cstep++;
        end
    end

    typedef struct {
        bit         unl;
        logic [7:0] chal;
        int         errk;      // RUN step whose response bit0 is flipped, -1 none
        bit         mid_start; // pulse START during RUN
        int         rst_step;  // RUN step at which reset hits, -1 none
        bit         exp_pass;
    } tvec_t;

    task automatic check_reset_vals(input string tag);
        chk({tag, "_A"}, PinA, 8'h00);
        chk({tag, "_OE"}, PinOE, 1);
        chk({tag, "_CCLR"}, PinCCLR, 1);
        chk({tag, "_BUSY"}, PinBUSY, 0);
        chk({tag, "_DONE"}, PinDONE, 0);
        chk({tag, "_PASS"}, PinPASS, 0);
        chk({tag, "_HITS"}, PinHITS, 8'h00);
    endtask

    task automatic session(input tvec_t v);
        int n, low;
        bit done_seen;
        unlock   = v.unl;
        chal     = v.chal;
        err_step = v.errk;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("s0_CCLR", PinCCLR, 0);
        chk("s0_BUSY", PinBUSY, 1);
        chk("s0_DONE", PinDONE, 0);
        chk("s0_PASS", PinPASS, 1);
        chk("s0_HITS", PinHITS, 0);
        low = 1;
        n = 0;
        done_seen = 0;
        while (n < 400 && !done_seen) begin
            if (v.mid_start && n == CLR + 10) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (!PinCCLR) low++;
            if (v.rst_step >= 0 && n == CLR + v.rst_step) begin
                rstn = 1'b0;
                #1;
                check_reset_vals("midrst");
                @(negedge clk);
                rstn = 1'b1;
                @(posedge clk); #1;
                chk("post_rst_BUSY", PinBUSY, 0);
                return;
            end
            if (PinDONE) done_seen = 1;
        end
        chk("done_seen", done_seen, 1);
        chk("session_len", n, CLR + STEPS);
        chk("cclr_low_clocks", low, CLR);
        chk("PASS", PinPASS, v.exp_pass);
        chk("HITS", PinHITS, (chits > 255) ? 255 : chits);
        chk("end_BUSY", PinBUSY, 0);
        chk("end_OE", PinOE, 1);
        chk("end_A", PinA, 8'h00);
`ifdef ACIDH_TRACE_EN
        chk("FSTEP", PinFSTEP, (v.errk >= 0) ? v.errk : 8'hFF);
        chk("FSIN", PinFSIN, (v.errk >= 0) ? exp_fsin : 8'h00);
`endif
    endtask

    tvec_t vecs[7];
    tvec_t rv;

    initial begin
        vecs[0] = '{unl:0, chal:8'h00, errk:-1, mid_start:0, rst_step:-1, exp_pass:1};
        vecs[1] = '{unl:1, chal:8'hA5, errk:-1, mid_start:0, rst_step:-1, exp_pass:1};
        vecs[2] = '{unl:0, chal:8'h00, errk: 5, mid_start:0, rst_step:-1, exp_pass:0};
        vecs[3] = '{unl:1, chal:8'h3C, errk:-1, mid_start:1, rst_step:-1, exp_pass:1};
        vecs[4] = '{unl:1, chal:8'h5A, errk:-1, mid_start:0, rst_step:20, exp_pass:1};
        vecs[5] = '{unl:1, chal:8'h5A, errk:63, mid_start:0, rst_step:-1, exp_pass:0};
        vecs[6] = '{unl:0, chal:8'hFF, errk: 0, mid_start:0, rst_step:-1, exp_pass:0};

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_BUSY", PinBUSY, 0);
            chk("idle_OE", PinOE, 1);
        end
        check_reset_vals("idle");

        for (int i = 0; i < 7; i++) session(vecs[i]);
        // Back-to-back into a clean session after a failing one.
        session(vecs[1]);

        for (int r = 0; r < 16; r++) begin
            rv.unl       = ($urandom % 4) != 0;
            rv.chal      = 8'($urandom);
            rv.errk      = (($urandom % 3) == 0) ? int'($urandom_range(0, STEPS - 1)) : -1;
            rv.mid_start = 0;
            rv.rst_step  = -1;
            rv.exp_pass  = (rv.errk < 0);
            session(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/acid_host.md
Name: acid_host

Overview:
- Host-side counterpart of the cartridge lock chip (CPC+ ASIC end of the lockout link).
- Pulses the cartridge clear, then runs a session of STEPS clocks. Each clock it drives an address byte with the select line low, and checks the cartridge's 8-bit response against a bit-exact internal model of the cartridge's 17-bit LFSR.
- When the model state allows it, it can inject unlock-match addresses.
- Reports busy, done, pass and a hit count to the system.

Parameters:
- STEPS, 64: number of checked RUN clocks per session (1..255).
- CLR_CYCLES, 2: number of clocks PinCCLR is held low (>=1).

Ports:
- PinCLK  in  1  system clock; all state changes on posedge; the cartridge samples on negedge.
- PinRESETn  in  1  asynchronous, active-low reset.
- PinSTART  in  1  single-clock pulse that begins a session.
- PinUNLOCK  in  1  enables match-address injection.
- PinCHAL  in  8  challenge byte, used when no match is injected.
- PinSIN  in  8  cartridge response byte.
- PinA  out  8  address byte to the cartridge.
- PinOE  out  1  active-low cartridge select.
- PinCCLR  out  1  active-low cartridge clear.
- PinBUSY  out  1  high in CLEAR and RUN.
- PinDONE  out  1  session finished.
- PinPASS  out  1  all checks matched.
- PinHITS  out  8  number of match steps, saturating at 255.

Behaviour:

Clock and reset:
- One clock, PinCLK.
- Reset is asynchronous, active-low, on PinRESETn.
- Reset values: state=IDLE, model=17'h1FFFF, PinA=8'h00, PinOE=1, PinCCLR=1, PinBUSY=0, PinDONE=0, PinPASS=0, PinHITS=0, step counter=0.
- Reset mid-session aborts immediately to these values. The next session re-clears the cartridge.

Step function step(S,A,oe):
- Cmp(A) = 17'h13596 ^ A0?0000C ^ A1?06000 ^ A2?000C0 ^ A3?00030 ^ A4?18000 ^ A5?00003 ^ A6?00600 ^ A7?01800.
- X(A) = 17'h0C820 ^ A0?00004 ^ A1?06000 ^ A2?00080 ^ A3?00020 ^ A4?08000 ^ A7?00800.
- match = !oe && ((S | 17'h00100) == Cmp(A)).
- T = match ? S^X(A) : S.
- step = {T[0]^T[9]^T[12]^T[16], T[16:1]}.

Matchable(S) and the injected address:
- matchable(S) is true iff S[b] != S[b+1] for every pair b in {0,2,4,6,9,11,13,15}.
- Injected address: A0=S[2]^1, A1=S[13]^1, A2=S[6], A3=S[4]^1, A4=S[15], A5=S[0], A6=S[9], A7=S[11].
- With this address, step() takes the match branch.

Drive rule, applied to a model value N:
- If PinUNLOCK && matchable(N): PinA <= injected address.
- Otherwise: PinA <= PinCHAL.
- PinOE <= 0.

State machine:
- IDLE:
  - PinSTART -> CLEAR.
  - On entry to CLEAR: PinCCLR<=0, model<=1FFFF, PinPASS<=1, PinDONE<=0, PinHITS<=0, PinBUSY<=1, counter<=0.
- CLEAR:
  - Holds PinCCLR low for CLR_CYCLES posedges.
  - On the last one: PinCCLR<=1, apply the drive rule to N=1FFFF (never matchable), -> RUN.
- RUN, each posedge:
  - E = step(model, PinA, PinOE).
  - If PinSIN != E[7:0]: PinPASS<=0 (sticky for the session).
  - model <= E.
  - If the match branch was taken: PinHITS++ (saturating at 255).
  - counter++.
  - Apply the drive rule to N=E.
  - After the STEPS-th comparison: PinA<=00, PinOE<=1, PinBUSY<=0, PinDONE<=1, -> DONE.
- DONE:
  - Outputs hold.
  - PinSTART starts a new session exactly as from IDLE.
- PinSTART is ignored in CLEAR and RUN.

Timing:
- The cartridge applies the step at the negedge after PinA/PinOE change, so PinSIN is stable at the next posedge.
- Session length is CLR_CYCLES + STEPS clocks from the START posedge to PinDONE high.

Optional Feature:
- Macro: ACIDH_TRACE_EN.
- Defined: adds outputs PinFSTEP[7:0] and PinFSIN[7:0].
  - These capture the counter value and the PinSIN value at the first mismatch of the session.
  - Reset and session start value is 8'hFF / 8'h00; later mismatches do not overwrite.
- Undefined: the ports are absent and there is no capture logic.
- Core behaviour is identical in both cases.

Test Plan:
1. Assert PinRESETn=0 -> PinA=00, PinOE=1, PinCCLR=1, BUSY/DONE/PASS=0, HITS=0; deassert and idle 10 clocks -> no change.
2. Bench cartridge-lock model in loopback, STEPS=64, CLR_CYCLES=2, PinUNLOCK=0, PinCHAL=00, START -> PinCCLR low for exactly 2 clocks, PinDONE high 66 clocks after START, PASS=1, HITS=0.
3. Same, PinUNLOCK=1, PinCHAL=A5 -> PASS=1; every cycle with matchable model shows PinA equal to the injected address; HITS equals the bench model's match count.
4. Loopback with PinSIN bit0 inverted on RUN step 5 only -> PASS=0, DONE=1, HITS unaffected; with ACIDH_TRACE_EN, PinFSTEP=05 and PinFSIN = expected^01.
5. START pulsed during RUN -> ignored, session length unchanged; PinRESETn low at RUN step 20 -> immediate reset values; new START -> full clean session, PASS=1.
6. Back-to-back: START in DONE -> DONE clears, PASS re-armed to 1, HITS cleared, second session passes.
